usb2_ep_arbiter: RTL and testbench
==================================

// Module: usb2_ep_arbiter
// PURPOSE
//  Shares the USB 2.0 protocol layer's single endpoint buffer interface between NUM_EP endpoint
//  blocks; EP0 control is endpoint 0.
//  Locks onto the endpoint named by the current token and routes the write stream, read data and
//  status to it. Sequences the commit/arm handshakes into the endpoints' synchronizing edge-detect
//  inputs, with a timeout on each handshake.
//  Keeps a per-endpoint data toggle bit for non-control endpoints.
// PARAMETERS
//  NUM_EP       4   number of endpoints attached, 1..15; ep index = USB endpoint number
//  ACK_TIMEOUT  16  cycles to wait for an endpoint commit_ack/arm_ack before aborting, >=8
// PORTS
//  phy_clk               in  1         clock; all logic on rising edge
//  reset                 in  1         synchronous, active-high
//  xfer_start            in  1         1-cycle pulse: token decoded, xfer_ep valid
//  xfer_ep               in  4         endpoint number of the current token
//  xfer_end              in  1         1-cycle pulse: transaction finished, release lock
//  prot_buf_in_addr      in  9         protocol write address
//  prot_buf_in_data      in  8         protocol write data
//  prot_buf_in_wren      in  1         protocol write strobe
//  prot_buf_in_ready     out 1         selected endpoint can accept OUT data
//  prot_buf_in_commit    in  1         1-cycle pulse: OUT packet complete
//  prot_buf_in_commit_len in 10        OUT packet length
//  prot_buf_in_commit_ack out 1        1-cycle pulse: endpoint accepted the commit
//  prot_buf_out_addr     in  9         protocol read address
//  prot_buf_out_q        out 8         read data from the selected endpoint
//  prot_buf_out_len      out 10        IN packet length of the selected endpoint
//  prot_buf_out_hasdata  out 1         selected endpoint has IN data
//  prot_buf_out_arm      in  1         1-cycle pulse: IN packet ACKed by the host
//  prot_buf_out_arm_ack  out 1         1-cycle pulse: endpoint acknowledged the arm
//  prot_data_toggle      out 1         toggle bit of the selected endpoint (0 = DATA0)
//  ep_buf_in_addr/data/commit_len  out 9/8/10  broadcast to all endpoints
//  ep_buf_out_addr       out 9         broadcast to all endpoints
//  ep_buf_in_wren        out NUM_EP    one-hot gated write strobe
//  ep_buf_in_ready       in  NUM_EP    per-endpoint ready
//  ep_buf_in_commit      out NUM_EP    per-endpoint commit level
//  ep_buf_in_commit_ack  in  NUM_EP    per-endpoint commit ack
//  ep_buf_out_q          in  8*NUM_EP  per-endpoint read data; ep i at [8i+7:8i]
//  ep_buf_out_len        in  10*NUM_EP per-endpoint IN length; ep i at [10i+9:10i]
//  ep_buf_out_hasdata    in  NUM_EP    per-endpoint hasdata
//  ep_buf_out_arm        out NUM_EP    per-endpoint arm level
//  ep_buf_out_arm_ack    in  NUM_EP    per-endpoint arm ack
//  toggle_clear          in  NUM_EP    force endpoint toggle to DATA0, e.g. on SET_CONFIG
//  err_bad_ep            out 1         1-cycle pulse: xfer_ep >= NUM_EP
//  err_timeout           out 1         1-cycle pulse: handshake timed out
// BEHAVIOUR
//  Reset: state IDLE, sel=0, all toggles 0, all outputs 0.
//  States:
//   IDLE: on xfer_start, latch sel<=xfer_ep; go to ACTIVE, or pulse err_bad_ep and stay IDLE
//     if xfer_ep >= NUM_EP.
//   ACTIVE: on xfer_end, go to IDLE. Otherwise, on commit, go to CMT; on arm, go to ARM.
//   CMT: ep_buf_in_commit[sel]=1, cnt counts up.
//     On the first cycle ack[sel]=1: drop commit, pulse prot_buf_in_commit_ack, flip toggle[sel]
//     (sel!=0), go to DRAIN.
//     If cnt==ACK_TIMEOUT: drop commit, pulse err_timeout, no flip, go to ACTIVE.
//   ARM: same as CMT, using ep_buf_out_arm / arm_ack / prot_buf_out_arm_ack.
//   DRAIN: wait until ack[sel]==0 (stretched ack, >=4 cycles) or ACK_TIMEOUT, then go to ACTIVE.
//     Prevents double-counting a stretched ack.
//  Routing is combinational, zero added latency, so endpoint RAM read latency is preserved:
//   ep_buf_in_wren[sel] = prot_buf_in_wren, only in ACTIVE.
//   prot_buf_out_q = q[sel].
//   ready, hasdata and len are muxed from [sel], and forced to 0 in IDLE.
//  Simultaneous commit+arm in ACTIVE: commit first. Arm is latched in a 1-deep pend flag and
//   serviced on return to ACTIVE. A second arm while pend is set is dropped.
//  xfer_end during CMT/ARM/DRAIN: held pending; the handshake completes first, then the block
//   goes to IDLE.
//  xfer_start in any non-IDLE state: ignored, sel unchanged.
//  toggle_clear[i] and a flip of i in the same cycle: clear wins.
//  Endpoint 0: toggle bit kept at 0 and never flips (EP0 drives its own DATA1).
//  cnt: $clog2(ACK_TIMEOUT+1) bits, saturating, cleared on every state entry.
//  Reset mid-handshake: commit/arm drop next cycle, pend and toggles cleared.
// TESTING
//  1. Reset; xfer_start ep=1; 4 wrens; commit; ep1 ack high 4 cycles.
//     -> only ep_buf_in_wren[1] fires; one commit_ack pulse; toggle 0->1; ACTIVE after ack falls.
//  2. ep=2 commit, ep never acks -> commit held exactly 16 cycles; err_timeout pulse; toggle unchanged.
//  3. xfer_ep=5 with NUM_EP=4 -> err_bad_ep pulse; ready=hasdata=0; state IDLE.
//  4. Commit and arm in the same cycle on ep1 -> commit handshake, then arm handshake; toggle flips twice.
//  5. toggle_clear[1] in the same cycle as the ep1 ack -> toggle[1]=0.
//  6. ep0 read: q/len routed from ep0 with no added delay -> prot_data_toggle stays 0.
//     Assert reset during ARM -> all arm outputs 0 next cycle.

Source files
------------

// File: rtl/usb2_ep_arbiter_if.sv
// Protocol-layer side of the endpoint buffer arbiter.
//   master : protocol layer (token/transaction pulses, write stream, read address,
//            commit/arm pulses; receives ready, read data, length, acks, toggle, errors)
//   slave  : arbiter
interface usb2_ep_arbiter_if;
  logic       xfer_start;
  logic [3:0] xfer_ep;
  logic       xfer_end;

  logic [8:0] prot_buf_in_addr;
  logic [7:0] prot_buf_in_data;
  logic       prot_buf_in_wren;
  logic       prot_buf_in_ready;
  logic       prot_buf_in_commit;
  logic [9:0] prot_buf_in_commit_len;
  logic       prot_buf_in_commit_ack;

  logic [8:0] prot_buf_out_addr;
  logic [7:0] prot_buf_out_q;
  logic [9:0] prot_buf_out_len;
  logic       prot_buf_out_hasdata;
  logic       prot_buf_out_arm;
  logic       prot_buf_out_arm_ack;

  logic       prot_data_toggle;
  logic       err_bad_ep;
  logic       err_timeout;

  modport master (
    output xfer_start, xfer_ep, xfer_end,
    output prot_buf_in_addr, prot_buf_in_data, prot_buf_in_wren,
    output prot_buf_in_commit, prot_buf_in_commit_len,
    output prot_buf_out_addr, prot_buf_out_arm,
    input  prot_buf_in_ready, prot_buf_in_commit_ack,
    input  prot_buf_out_q, prot_buf_out_len, prot_buf_out_hasdata, prot_buf_out_arm_ack,
    input  prot_data_toggle, err_bad_ep, err_timeout
  );

  modport slave (
    input  xfer_start, xfer_ep, xfer_end,
    input  prot_buf_in_addr, prot_buf_in_data, prot_buf_in_wren,
    input  prot_buf_in_commit, prot_buf_in_commit_len,
    input  prot_buf_out_addr, prot_buf_out_arm,
    output prot_buf_in_ready, prot_buf_in_commit_ack,
    output prot_buf_out_q, prot_buf_out_len, prot_buf_out_hasdata, prot_buf_out_arm_ack,
    output prot_data_toggle, err_bad_ep, err_timeout
  );
endinterface

// File: rtl/usb2_ep_arbiter.sv
// Shares the protocol layer's single endpoint buffer interface between NUM_EP endpoints.
// Locks onto the token's endpoint, routes write stream / read data / status to it with no
// added latency, sequences commit/arm handshakes with a timeout, and keeps per-endpoint
// data toggles (endpoint 0 toggle is always DATA0).
// Ports:
//   phy_clk, reset        clock, synchronous active-high reset
//   prot                  protocol-side bus (slave modport)
//   ep_buf_in_*/out_*     endpoint-side broadcast and per-endpoint vectors
//   toggle_clear          per-endpoint force of the toggle to DATA0
module usb2_ep_arbiter #(
  parameter int unsigned NUM_EP      = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   phy_clk,
  input  logic                   reset,
  usb2_ep_arbiter_if.slave       prot,
  output logic [8:0]             ep_buf_in_addr,
  output logic [7:0]             ep_buf_in_data,
  output logic [9:0]             ep_buf_in_commit_len,
  output logic [8:0]             ep_buf_out_addr,
  output logic [NUM_EP-1:0]      ep_buf_in_wren,
  input  logic [NUM_EP-1:0]      ep_buf_in_ready,
  output logic [NUM_EP-1:0]      ep_buf_in_commit,
  input  logic [NUM_EP-1:0]      ep_buf_in_commit_ack,
  input  logic [8*NUM_EP-1:0]    ep_buf_out_q,
  input  logic [10*NUM_EP-1:0]   ep_buf_out_len,
  input  logic [NUM_EP-1:0]      ep_buf_out_hasdata,
  output logic [NUM_EP-1:0]      ep_buf_out_arm,
  input  logic [NUM_EP-1:0]      ep_buf_out_arm_ack,
  input  logic [NUM_EP-1:0]      toggle_clear
);

  localparam int unsigned SEL_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ACTIVE, CMT, ARM, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_arm_q, pend_arm_d;
  logic               pend_end_q, pend_end_d;
  logic               hs_arm_q, hs_arm_d;
  logic               commit_ack_q, commit_ack_d;
  logic               arm_ack_q, arm_ack_d;
  logic               err_bad_ep_q, err_bad_ep_d;
  logic               err_timeout_q, err_timeout_d;
  logic [NUM_EP-1:0]  toggle_q, toggle_d;

  logic               flip;
  logic               hs_ack;
  logic               hs_expired;
  logic               end_req;

  logic [7:0]         q_arr   [NUM_EP];
  logic [9:0]         len_arr [NUM_EP];

  // Unpack the per-endpoint read buses.
  for (genvar i = 0; i < NUM_EP; i++) begin : g_unpack
    assign q_arr[i]   = ep_buf_out_q[8*i +: 8];
    assign len_arr[i] = ep_buf_out_len[10*i +: 10];
  end

  // Broadcast buses and zero-latency routing to/from the selected endpoint.
  always_comb begin
    ep_buf_in_addr       = prot.prot_buf_in_addr;
    ep_buf_in_data       = prot.prot_buf_in_data;
    ep_buf_in_commit_len = prot.prot_buf_in_commit_len;
    ep_buf_out_addr      = prot.prot_buf_out_addr;

    ep_buf_in_wren   = '0;
    ep_buf_in_commit = '0;
    ep_buf_out_arm   = '0;
    ep_buf_in_wren[sel_q]   = (state_q == ACTIVE) & prot.prot_buf_in_wren;
    ep_buf_in_commit[sel_q] = (state_q == CMT);
    ep_buf_out_arm[sel_q]   = (state_q == ARM);

    prot.prot_buf_out_q       = q_arr[sel_q];
    prot.prot_buf_in_ready    = (state_q != IDLE) & ep_buf_in_ready[sel_q];
    prot.prot_buf_out_hasdata = (state_q != IDLE) & ep_buf_out_hasdata[sel_q];
    prot.prot_buf_out_len     = (state_q != IDLE) ? len_arr[sel_q] : 10'd0;

    prot.prot_buf_in_commit_ack = commit_ack_q;
    prot.prot_buf_out_arm_ack   = arm_ack_q;
    prot.prot_data_toggle       = toggle_q[sel_q];
    prot.err_bad_ep             = err_bad_ep_q;
    prot.err_timeout            = err_timeout_q;
  end

  // Next-state, handshake sequencing and toggle update.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = (cnt_q == CNT_W'(ACK_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    pend_arm_d    = pend_arm_q;
    pend_end_d    = pend_end_q;
    hs_arm_d      = hs_arm_q;
    commit_ack_d  = 1'b0;
    arm_ack_d     = 1'b0;
    err_bad_ep_d  = 1'b0;
    err_timeout_d = 1'b0;
    flip          = 1'b0;
    toggle_d      = toggle_q;

    hs_ack     = hs_arm_q ? ep_buf_out_arm_ack[sel_q] : ep_buf_in_commit_ack[sel_q];
    // cnt_q counts cycles already spent in the state, so this is the ACK_TIMEOUT-th one.
    hs_expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    end_req    = pend_end_q | prot.xfer_end;

    unique case (state_q)
      IDLE: begin
        if (prot.xfer_start) begin
          if (prot.xfer_ep >= 4'(NUM_EP)) begin
            err_bad_ep_d = 1'b1;
          end else begin
            sel_d   = SEL_W'(prot.xfer_ep);
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (prot.xfer_end) begin
          state_d = IDLE;
        end else if (prot.prot_buf_in_commit) begin
          // Commit wins a tie; a coincident arm waits in the pend flag.
          state_d    = CMT;
          hs_arm_d   = 1'b0;
          pend_arm_d = pend_arm_q | prot.prot_buf_out_arm;
        end else if (prot.prot_buf_out_arm | pend_arm_q) begin
          state_d    = ARM;
          hs_arm_d   = 1'b1;
          pend_arm_d = 1'b0;
        end
      end
      CMT, ARM: begin
        pend_arm_d = pend_arm_q | prot.prot_buf_out_arm;
        pend_end_d = end_req;
        if (hs_ack) begin
          state_d      = DRAIN;
          flip         = 1'b1;
          commit_ack_d = ~hs_arm_q;
          arm_ack_d    = hs_arm_q;
        end else if (hs_expired) begin
          err_timeout_d = 1'b1;
          state_d       = end_req ? IDLE : ACTIVE;
        end
      end
      DRAIN: begin
        // Wait out a stretched ack so it is not counted twice.
        pend_arm_d = pend_arm_q | prot.prot_buf_out_arm;
        pend_end_d = end_req;
        if (!hs_ack || hs_expired) begin
          state_d = end_req ? IDLE : ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      pend_arm_d = 1'b0;
      pend_end_d = 1'b0;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    for (int unsigned i = 1; i < NUM_EP; i++) begin
      if (flip && (sel_q == SEL_W'(i))) begin
        toggle_d[i] = ~toggle_q[i];
      end
    end
    toggle_d    = toggle_d & ~toggle_clear;
    toggle_d[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      pend_arm_q    <= 1'b0;
      pend_end_q    <= 1'b0;
      hs_arm_q      <= 1'b0;
      commit_ack_q  <= 1'b0;
      arm_ack_q     <= 1'b0;
      err_bad_ep_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      toggle_q      <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      pend_arm_q    <= pend_arm_d;
      pend_end_q    <= pend_end_d;
      hs_arm_q      <= hs_arm_d;
      commit_ack_q  <= commit_ack_d;
      arm_ack_q     <= arm_ack_d;
      err_bad_ep_q  <= err_bad_ep_d;
      err_timeout_q <= err_timeout_d;
      toggle_q      <= toggle_d;
    end
  end

endmodule

// File: tb/tb_usb2_ep_arbiter.sv
// Directed bench for usb2_ep_arbiter with NUM_EP=4, ACK_TIMEOUT=16.
module tb_usb2_ep_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  ep_buf_in_addr;
  logic [7:0]  ep_buf_in_data;
  logic [9:0]  ep_buf_in_commit_len;
  logic [8:0]  ep_buf_out_addr;
  logic [3:0]  ep_buf_in_wren;
  logic [3:0]  ep_buf_in_ready;
  logic [3:0]  ep_buf_in_commit;
  logic [3:0]  ep_buf_in_commit_ack;
  logic [31:0] ep_buf_out_q;
  logic [39:0] ep_buf_out_len;
  logic [3:0]  ep_buf_out_hasdata;
  logic [3:0]  ep_buf_out_arm;
  logic [3:0]  ep_buf_out_arm_ack;
  logic [3:0]  toggle_clear;

  int checks   = 0;
  int failures = 0;
  int n_cack = 0, n_aack = 0, n_to = 0, n_clvl = 0;
  int s_cack, s_aack, s_to, s_clvl;

  usb2_ep_arbiter_if prot_if ();

  usb2_ep_arbiter #(.NUM_EP(4), .ACK_TIMEOUT(16)) dut (
    .phy_clk              (clk),
    .reset                (reset),
    .prot                 (prot_if),
    .ep_buf_in_addr       (ep_buf_in_addr),
    .ep_buf_in_data       (ep_buf_in_data),
    .ep_buf_in_commit_len (ep_buf_in_commit_len),
    .ep_buf_out_addr      (ep_buf_out_addr),
    .ep_buf_in_wren       (ep_buf_in_wren),
    .ep_buf_in_ready      (ep_buf_in_ready),
    .ep_buf_in_commit     (ep_buf_in_commit),
    .ep_buf_in_commit_ack (ep_buf_in_commit_ack),
    .ep_buf_out_q         (ep_buf_out_q),
    .ep_buf_out_len       (ep_buf_out_len),
    .ep_buf_out_hasdata   (ep_buf_out_hasdata),
    .ep_buf_out_arm       (ep_buf_out_arm),
    .ep_buf_out_arm_ack   (ep_buf_out_arm_ack),
    .toggle_clear         (toggle_clear)
  );

  always #5 clk = ~clk;

  // Pulse / level counters sampled on the falling edge.
  always @(negedge clk) begin
    if (prot_if.prot_buf_in_commit_ack) n_cack <= n_cack + 1;
    if (prot_if.prot_buf_out_arm_ack)   n_aack <= n_aack + 1;
    if (prot_if.err_timeout)            n_to   <= n_to + 1;
    if (ep_buf_in_commit != 4'b0)       n_clvl <= n_clvl + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] ep;
    logic       bad;
    logic       ready;
    logic       hasdata;
    logic [9:0] len;
    logic [7:0] q;
    logic [3:0] wren;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_cack = n_cack; s_aack = n_aack; s_to = n_to; s_clvl = n_clvl;
  endtask

  // Wait for the handshake level on ep, then hold the ack high for `hold` cycles.
  task automatic ep_ack(input bit is_arm, input int ep, input int hold, input logic [3:0] clr);
    int   w = 0;
    logic lvl;
    lvl = is_arm ? ep_buf_out_arm[ep] : ep_buf_in_commit[ep];
    while (!lvl && w < 30) begin
      step();
      w++;
      lvl = is_arm ? ep_buf_out_arm[ep] : ep_buf_in_commit[ep];
    end
    chk(is_arm ? "arm_level_seen" : "commit_level_seen", 32'(lvl), 32'd1);
    if (is_arm) ep_buf_out_arm_ack[ep] = 1'b1;
    else        ep_buf_in_commit_ack[ep] = 1'b1;
    toggle_clear = clr;
    step();
    toggle_clear = 4'b0;
    for (int i = 1; i < hold; i++) step();
    if (is_arm) ep_buf_out_arm_ack[ep] = 1'b0;
    else        ep_buf_in_commit_ack[ep] = 1'b0;
    step();
  endtask

  task automatic start_ep(input logic [3:0] ep);
    prot_if.xfer_ep    = ep;
    prot_if.xfer_start = 1'b1;
    step();
    prot_if.xfer_start = 1'b0;
  endtask

  task automatic end_xfer();
    prot_if.xfer_end = 1'b1;
    step();
    prot_if.xfer_end = 1'b0;
  endtask

  initial begin
    tbl[0] = '{ep: 4'd0,  bad: 1'b0, ready: 1'b0, hasdata: 1'b0, len: 10'h100, q: 8'hA0, wren: 4'b0001};
    tbl[1] = '{ep: 4'd1,  bad: 1'b0, ready: 1'b1, hasdata: 1'b1, len: 10'h103, q: 8'hA1, wren: 4'b0010};
    tbl[2] = '{ep: 4'd2,  bad: 1'b0, ready: 1'b0, hasdata: 1'b1, len: 10'h106, q: 8'hA2, wren: 4'b0100};
    tbl[3] = '{ep: 4'd3,  bad: 1'b0, ready: 1'b1, hasdata: 1'b0, len: 10'h109, q: 8'hA3, wren: 4'b1000};
    tbl[4] = '{ep: 4'd5,  bad: 1'b1, ready: 1'b0, hasdata: 1'b0, len: 10'h000, q: 8'h00, wren: 4'b0000};
    tbl[5] = '{ep: 4'd15, bad: 1'b1, ready: 1'b0, hasdata: 1'b0, len: 10'h000, q: 8'h00, wren: 4'b0000};

    reset = 1'b1;
    prot_if.xfer_start = 1'b0; prot_if.xfer_ep = 4'd0; prot_if.xfer_end = 1'b0;
    prot_if.prot_buf_in_addr = 9'd0; prot_if.prot_buf_in_data = 8'd0;
    prot_if.prot_buf_in_wren = 1'b0; prot_if.prot_buf_in_commit = 1'b0;
    prot_if.prot_buf_in_commit_len = 10'd0; prot_if.prot_buf_out_addr = 9'd0;
    prot_if.prot_buf_out_arm = 1'b0;
    ep_buf_in_ready      = 4'b1010;
    ep_buf_out_hasdata   = 4'b0110;
    ep_buf_out_q         = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ep_buf_out_len       = {10'h109, 10'h106, 10'h103, 10'h100};
    ep_buf_in_commit_ack = 4'b0;
    ep_buf_out_arm_ack   = 4'b0;
    toggle_clear         = 4'b0;

    // Reset state
    repeat (3) step();
    chk("rst_commit",   32'(ep_buf_in_commit), 32'd0);
    chk("rst_arm",      32'(ep_buf_out_arm), 32'd0);
    chk("rst_cack",     32'(prot_if.prot_buf_in_commit_ack), 32'd0);
    chk("rst_aack",     32'(prot_if.prot_buf_out_arm_ack), 32'd0);
    chk("rst_bad_ep",   32'(prot_if.err_bad_ep), 32'd0);
    chk("rst_timeout",  32'(prot_if.err_timeout), 32'd0);
    chk("rst_toggle",   32'(prot_if.prot_data_toggle), 32'd0);
    chk("rst_ready",    32'(prot_if.prot_buf_in_ready), 32'd0);
    chk("rst_hasdata",  32'(prot_if.prot_buf_out_hasdata), 32'd0);
    chk("rst_len",      32'(prot_if.prot_buf_out_len), 32'd0);
    reset = 1'b0;
    step();

    // Routing / bad-endpoint table
    for (int k = 0; k < 6; k++) begin
      start_ep(tbl[k].ep);
      prot_if.prot_buf_in_wren = 1'b1;
      #1;
      chk($sformatf("tbl%0d_bad_ep", k),  32'(prot_if.err_bad_ep), 32'(tbl[k].bad));
      chk($sformatf("tbl%0d_ready", k),   32'(prot_if.prot_buf_in_ready), 32'(tbl[k].ready));
      chk($sformatf("tbl%0d_hasdata", k), 32'(prot_if.prot_buf_out_hasdata), 32'(tbl[k].hasdata));
      chk($sformatf("tbl%0d_len", k),     32'(prot_if.prot_buf_out_len), 32'(tbl[k].len));
      chk($sformatf("tbl%0d_wren", k),    32'(ep_buf_in_wren), 32'(tbl[k].wren));
      if (!tbl[k].bad) chk($sformatf("tbl%0d_q", k), 32'(prot_if.prot_buf_out_q), 32'(tbl[k].q));
      prot_if.prot_buf_in_wren = 1'b0;
      end_xfer();
      chk($sformatf("tbl%0d_idle_ready", k), 32'(prot_if.prot_buf_in_ready), 32'd0);
      chk($sformatf("tbl%0d_bad_ep_gone", k), 32'(prot_if.err_bad_ep), 32'd0);
    end

    // Test 1: ep1 writes + commit, stretched ack
    start_ep(4'd1);
    start_ep(4'd3);  // ignored while locked
    chk("t1_sel_kept_q", 32'(prot_if.prot_buf_out_q), 32'h0A1);
    for (int k = 0; k < 4; k++) begin
      prot_if.prot_buf_in_wren = 1'b1;
      prot_if.prot_buf_in_addr = 9'(k + 3);
      prot_if.prot_buf_in_data = 8'(8'h40 + k);
      #1;
      chk("t1_wren_onehot", 32'(ep_buf_in_wren), 32'b0010);
      chk("t1_addr_bcast",  32'(ep_buf_in_addr), 32'(k + 3));
      step();
    end
    prot_if.prot_buf_in_wren = 1'b0;
    snap();
    prot_if.prot_buf_in_commit     = 1'b1;
    prot_if.prot_buf_in_commit_len = 10'd4;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    chk("t1_commit_level", 32'(ep_buf_in_commit), 32'b0010);
    chk("t1_commit_len",   32'(ep_buf_in_commit_len), 32'd4);
    step(); step();
    ep_buf_in_commit_ack[1] = 1'b1;
    step();
    chk("t1_commit_dropped", 32'(ep_buf_in_commit), 32'd0);
    chk("t1_toggle_flip",    32'(prot_if.prot_data_toggle), 32'd1);
    step();
    prot_if.prot_buf_in_wren = 1'b1;
    #1;
    chk("t1_drain_no_wren", 32'(ep_buf_in_wren), 32'd0);
    prot_if.prot_buf_in_wren = 1'b0;
    step(); step();
    ep_buf_in_commit_ack[1] = 1'b0;
    step();
    prot_if.prot_buf_in_wren = 1'b1;
    #1;
    chk("t1_active_after_drain", 32'(ep_buf_in_wren), 32'b0010);
    prot_if.prot_buf_in_wren = 1'b0;
    chk("t1_cack_count", 32'(n_cack - s_cack), 32'd1);
    chk("t1_commit_cycles", 32'(n_clvl - s_clvl), 32'd3);
    step();

    // Test 2: ep2 never acks; xfer_end pending during the handshake
    end_xfer();
    start_ep(4'd2);
    snap();
    prot_if.prot_buf_in_commit = 1'b1;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    chk("t2_commit_level", 32'(ep_buf_in_commit), 32'b0100);
    step();
    end_xfer();
    for (int k = 0; k < 24; k++) step();
    chk("t2_commit_cycles", 32'(n_clvl - s_clvl), 32'd16);
    chk("t2_timeout_pulse", 32'(n_to - s_to), 32'd1);
    chk("t2_no_cack",       32'(n_cack - s_cack), 32'd0);
    chk("t2_commit_low",    32'(ep_buf_in_commit), 32'd0);
    chk("t2_toggle",        32'(prot_if.prot_data_toggle), 32'd0);
    prot_if.prot_buf_in_wren = 1'b1;
    #1;
    chk("t2_idle_after_end", 32'(ep_buf_in_wren), 32'd0);
    prot_if.prot_buf_in_wren = 1'b0;
    step();

    // Test 4: simultaneous commit + arm on ep1 (toggle starts at 1)
    start_ep(4'd1);
    snap();
    prot_if.prot_buf_in_commit = 1'b1;
    prot_if.prot_buf_out_arm   = 1'b1;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    prot_if.prot_buf_out_arm   = 1'b0;
    chk("t4_commit_first", 32'(ep_buf_in_commit), 32'b0010);
    chk("t4_arm_waits",    32'(ep_buf_out_arm), 32'd0);
    ep_ack(1'b0, 1, 4, 4'b0);
    chk("t4_toggle_after_commit", 32'(prot_if.prot_data_toggle), 32'd0);
    ep_ack(1'b1, 1, 4, 4'b0);
    chk("t4_toggle_after_arm", 32'(prot_if.prot_data_toggle), 32'd1);
    chk("t4_cack_count", 32'(n_cack - s_cack), 32'd1);
    chk("t4_aack_count", 32'(n_aack - s_aack), 32'd1);
    step(); step();
    chk("t4_no_extra_arm", 32'(ep_buf_out_arm), 32'd0);

    // Test 5: toggle_clear coincident with the ack flip
    prot_if.prot_buf_in_commit = 1'b1;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    ep_ack(1'b0, 1, 4, 4'b0);
    chk("t5_toggle_to_0", 32'(prot_if.prot_data_toggle), 32'd0);
    prot_if.prot_buf_in_commit = 1'b1;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    ep_ack(1'b0, 1, 4, 4'b0010);
    chk("t5_clear_wins", 32'(prot_if.prot_data_toggle), 32'd0);
    prot_if.prot_buf_in_commit = 1'b1;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    ep_ack(1'b0, 1, 4, 4'b0);
    chk("t5_toggle_to_1", 32'(prot_if.prot_data_toggle), 32'd1);

    // Test 6: ep0 routing, ep0 toggle, reset during ARM
    end_xfer();
    start_ep(4'd0);
    ep_buf_out_q[7:0] = 8'h5C;
    #1;
    chk("t6_q_zero_latency", 32'(prot_if.prot_buf_out_q), 32'h05C);
    ep_buf_out_len[9:0] = 10'h2AB;
    #1;
    chk("t6_len_zero_latency", 32'(prot_if.prot_buf_out_len), 32'h2AB);
    snap();
    prot_if.prot_buf_in_commit = 1'b1;
    step();
    prot_if.prot_buf_in_commit = 1'b0;
    ep_ack(1'b0, 0, 4, 4'b0);
    chk("t6_ep0_cack",   32'(n_cack - s_cack), 32'd1);
    chk("t6_ep0_toggle", 32'(prot_if.prot_data_toggle), 32'd0);
    prot_if.prot_buf_out_arm = 1'b1;
    step();
    prot_if.prot_buf_out_arm = 1'b0;
    chk("t6_arm_level", 32'(ep_buf_out_arm), 32'b0001);
    reset = 1'b1;
    step();
    chk("t6_rst_arm",  32'(ep_buf_out_arm), 32'd0);
    chk("t6_rst_aack", 32'(prot_if.prot_buf_out_arm_ack), 32'd0);
    reset = 1'b0;
    step();
    start_ep(4'd1);
    chk("t6_rst_toggle_cleared", 32'(prot_if.prot_data_toggle), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
